adapter_to_bus: RTL and testbench

Serialises 128-bit message words into a stream of 32-bit bus beats with an end-of-message marker. Sits directly upstream of the bus-to-word assembler: its `out$enq` beat stream is the assembler's `in$enq` input. Together the pair round-trips a 128-bit word through a 32-bit bus. Beats are emitted most-significant first, so the assembler's shift-left packing reconstructs the original word.

---
 rtl/adapter_to_bus.sv | 42 ++++
 tb/tb_adapter_to_bus.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adapter_to_bus.sv
// adapter_to_bus: serialises 128-bit words into MSB-first 32-bit beats with an end-of-message marker
module adapter_to_bus (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         in_enq_ena,
  input  logic [127:0] in_enq_v,
  input  logic [15:0]  in_enq_length,
  output logic         in_enq_rdy,
  output logic         out_enq_ena,
  output logic [31:0]  out_enq_v,
  output logic         out_enq_last,
  input  logic         out_enq_rdy
);
  logic [127:0] buffer;
  logic [2:0]   remaining;
  logic [2:0]   beats;
  logic         busy;
  logic         accept;
  logic         xfer;
  assign busy         = remaining != 3'd0;
  assign out_enq_ena  = busy;
  assign out_enq_v    = buffer[127:96];
  assign out_enq_last = busy & (remaining == 3'd1);
  assign in_enq_rdy   = !busy | ((remaining == 3'd1) & out_enq_rdy);
  assign accept       = in_enq_ena & in_enq_rdy;
  assign xfer         = out_enq_ena & out_enq_rdy;
  always_comb
    beats = (in_enq_length == 16'd0 || in_enq_length > 16'd96) ? 3'd4 :
            (in_enq_length > 16'd64) ? 3'd3 :
            (in_enq_length > 16'd32) ? 3'd2 : 3'd1;
  always_ff @(posedge CLK)
    if (!nRST) begin
      buffer    <= '0;
      remaining <= '0;
    end else if (accept) begin
      buffer    <= in_enq_v;
      remaining <= beats;
    end else if (xfer) begin
      buffer    <= {buffer[95:0], 32'h0};
      remaining <= remaining - 3'd1;
    end
endmodule

// File: tb/tb_adapter_to_bus.sv
// tb_adapter_to_bus: random and directed stimulus against a beat-queue model with loopback reassembly
module tb_adapter_to_bus;
  logic         CLK = 1'b0;
  logic         nRST;
  logic         in_ena;
  logic [127:0] in_v;
  logic [15:0]  in_len;
  logic         in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_last;
  logic         out_rdy;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  beat_t        q[$];
  logic [127:0] aq[$];
  logic [127:0] acc = '0;
  int           words_sent;
  localparam logic [127:0] W = 128'h00010203_04050607_08090A0B_0C0D0E0F;

  adapter_to_bus dut (
    .CLK(CLK), .nRST(nRST),
    .in_enq_ena(in_ena), .in_enq_v(in_v), .in_enq_length(in_len), .in_enq_rdy(in_rdy),
    .out_enq_ena(out_ena), .out_enq_v(out_v), .out_enq_last(out_last), .out_enq_rdy(out_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbeats(input logic [15:0] len);
    return (len == 0 || len > 96) ? 4 : (int'(len) + 31) / 32;
  endfunction

  task automatic cycle(input logic ena, input logic [127:0] v, input logic [15:0] len, input logic ordy);
    logic        take, moved;
    logic [31:0] seen;
    int          n;
    in_ena = ena; in_v = v; in_len = len; out_rdy = ordy;
    @(negedge CLK);
    chk("out_ena", out_ena, q.size() != 0);
    chk("last", out_last, q.size() == 1);
    if (q.size() != 0) chk("beat", out_v, q[0].d);
    chk("in_rdy", in_rdy, q.size() == 0 || (q.size() == 1 && ordy));
    take  = ena && (q.size() == 0 || (q.size() == 1 && ordy));
    moved = q.size() != 0 && ordy;
    seen  = out_v;
    @(posedge CLK);
    if (moved) begin
      acc = {acc[95:0], seen};
      if (q[0].l) begin
        chk("word", acc, aq.pop_front());
        acc = '0;
      end
      void'(q.pop_front());
    end
    if (take) begin
      n = nbeats(len);
      for (int i = 0; i < n; i++) q.push_back('{v[127-32*i -: 32], i == n - 1});
      aq.push_back(v >> (128 - 32 * n));
      words_sent++;
    end
    #1;
  endtask

  task automatic rst_cycle();
    nRST = 1'b0; in_ena = 1'b0; out_rdy = 1'b1;
    @(posedge CLK);
    #1 nRST = 1'b1;
    q.delete(); aq.delete(); acc = '0;
    @(negedge CLK);
    chk("rst_ena", out_ena, 0);
    chk("rst_last", out_last, 0);
    chk("rst_v", out_v, 0);
    chk("rst_rdy", in_rdy, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 16'd0, 1'b1);
  endtask

  initial begin
    logic [127:0] a, b;
    logic [15:0]  lens [10] = '{16'd0, 16'd1, 16'd32, 16'd33, 16'd64, 16'd65, 16'd96, 16'd97, 16'd128, 16'd200};
    nRST = 1'b0; in_ena = 1'b0; in_v = '0; in_len = '0; out_rdy = 1'b1;
    words_sent = 0;
    rst_cycle();
    cycle(1'b1, W, 16'd0, 1'b1);
    idle(5);
    foreach (lens[i]) begin
      cycle(1'b1, W, lens[i], 1'b1);
      idle(5);
    end
    cycle(1'b1, W, 16'd0, 1'b1);
    cycle(1'b0, '0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, ~W, 16'd0, 1'b0);
    idle(4);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, a, 16'd64, 1'b1);
    cycle(1'b0, '0, 16'd0, 1'b1);
    cycle(1'b1, b, 16'd32, 1'b1);
    idle(2);
    cycle(1'b1, W, 16'd0, 1'b1);
    cycle(1'b0, '0, 16'd0, 1'b1);
    rst_cycle();
    cycle(1'b1, W, 16'd16, 1'b1);
    idle(2);
    words_sent = 0;
    for (int i = 0; i < 2000 && words_sent < 100; i++)
      cycle(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'd0, ($urandom % 4) != 0);
    chk("loop_words", words_sent, 100);
    idle(5);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), {$urandom, $urandom, $urandom, $urandom}, lens[$urandom % 10], 1'($urandom));
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
